mod_exp: RTL and testbench

//  Modular exponentiation engine: z = x^e mod n, left-to-right square-and-multiply.

---
 rtl/mod_exp.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_mod_exp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mod_exp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mod_exp : modular exponentiation z = x^e mod n, left-to-right
//           square-and-multiply around a single shared mod_mul instance.
//
// Optional feature macro: MOD_EXP_SKIP_LZ_EN
//   defined   : leading zero bits of e are skipped. The first real step is
//               acc = 1 * x, and e == 0 finishes without any modular multiply.
//   undefined : exactly e_bit squarings per operation, so the latency depends
//               only on popcount(e).
//   Results are identical in both builds.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset; aborts any operation
//   start  in   1      level request, sampled only in IDLE. After a capture it
//                      must be seen low for at least one cycle before it can
//                      trigger again.
//   x      in   n_bit  base (must be < n), captured together with start
//   e      in   e_bit  exponent, captured together with start
//   z      out  n_bit  registered result, held until the next result
//   done   out  1      one-cycle pulse; z is valid in the same cycle
//   busy   out  1      high from the cycle after capture through the done cycle
//
// mod_mul (also in this file) computes x*y mod n with normal-domain operands.
// It runs two Montgomery passes: mont(x, y) and then mont(., R^2 mod n).
// -----------------------------------------------------------------------------

module mod_mul #(
  parameter int               n_bit  = 7,
  parameter int               logr   = 5,
  parameter logic [n_bit-1:0] n      = 7'd79,
  parameter logic [logr-1:0]  p      = 5'd17,  // -n^-1 mod 2^logr
  parameter logic [n_bit-1:0] r2modn = 7'd9    // R^2 mod n, R = 2^(k*logr)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [n_bit-1:0] x_i,
  input  logic [n_bit-1:0] y_i,
  output logic [n_bit-1:0] z_o,
  output logic             done_o
);

  localparam int K  = (n_bit + logr - 1) / logr;  // radix-2^logr digits per operand
  localparam int BW = K * logr;
  localparam int TW = n_bit + logr + 2;           // holds t + a*d + q*n (t < 2n)
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;

  mstate_t          state_q, state_d;
  logic [n_bit-1:0] a_q, a_d;
  logic [BW-1:0]    b_q, b_d;
  logic [TW-1:0]    t_q, t_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pass_q, pass_d;   // 0: mont(x,y)  1: mont(., R^2 mod n)
  logic [n_bit-1:0] z_q, z_d;

  logic [TW-1:0]    sum_ab, sum_qn, t_next, t_red;
  logic [logr-1:0]  q_dig;

  // One Montgomery digit step: t = (t + a*b_j + q*n) / 2^logr.
  always_comb begin
    sum_ab = t_q + TW'(a_q) * TW'(b_q[logr-1:0]);
    q_dig  = sum_ab[logr-1:0] * p;
    sum_qn = sum_ab + TW'(q_dig) * TW'(n);
    t_next = sum_qn >> logr;
    t_red  = (t_next >= TW'(n)) ? t_next - TW'(n) : t_next;
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    z_d     = z_q;
    unique case (state_q)
      M_IDLE: begin
        if (start_i) begin
          a_d     = x_i;
          b_d     = BW'(y_i);
          t_d     = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = M_RUN;
        end
      end
      M_RUN: begin
        t_d   = t_next;
        b_d   = b_q >> logr;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(K - 1)) begin
          if (!pass_q) begin
            // Result is x*y*R^-1; a second pass with R^2 restores the normal domain.
            a_d    = t_red[n_bit-1:0];
            b_d    = BW'(r2modn);
            t_d    = '0;
            cnt_d  = '0;
            pass_d = 1'b1;
          end else begin
            z_d     = t_red[n_bit-1:0];
            state_d = M_DONE;
          end
        end
      end
      M_DONE:  state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= M_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      z_q     <= z_d;
    end
  end

  assign z_o    = z_q;
  assign done_o = (state_q == M_DONE);

endmodule

module mod_exp #(
  parameter int               n_bit  = 7,
  parameter int               e_bit  = 8,
  parameter int               logr   = 5,
  parameter logic [n_bit-1:0] n      = 7'd79,
  parameter logic [logr-1:0]  p      = 5'd17,
  parameter logic [n_bit-1:0] R2modn = 7'd9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [n_bit-1:0] x,
  input  logic [e_bit-1:0] e,
  output logic [n_bit-1:0] z,
  output logic             done,
  output logic             busy
);

  localparam int IW = (e_bit > 1) ? $clog2(e_bit) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQR  = 3'd1,
    S_CHK  = 3'd2,
    S_MUL  = 3'd3,
    S_NXT  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [n_bit-1:0] xr_q, xr_d;
  logic [e_bit-1:0] er_q, er_d;
  logic [n_bit-1:0] acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d;
  logic [n_bit-1:0] z_q, z_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;  // start has been seen low since the last capture

  logic             mm_start, mm_done;
  logic [n_bit-1:0] mm_x, mm_y, mm_z;

`ifdef MOD_EXP_SKIP_LZ_EN
  function automatic logic [IW-1:0] msb_idx(input logic [e_bit-1:0] v);
    msb_idx = '0;
    for (int k = 0; k < e_bit; k++) begin
      if (v[k]) msb_idx = IW'(k);
    end
  endfunction
`endif

  // CHK and NXT hold mm_start low, so mod_mul always sees a low cycle
  // between two operations and cannot retrigger on a stale request.
  assign mm_start = (state_q == S_SQR) || (state_q == S_MUL);
  assign mm_x     = acc_q;
  assign mm_y     = (state_q == S_MUL) ? xr_q : acc_q;

  mod_mul #(
    .n_bit  (n_bit),
    .logr   (logr),
    .n      (n),
    .p      (p),
    .r2modn (R2modn)
  ) u_mod_mul (
    .clk     (clk),
    .rst_n   (~rst),
    .start_i (mm_start),
    .x_i     (mm_x),
    .y_i     (mm_y),
    .z_o     (mm_z),
    .done_o  (mm_done)
  );

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    er_d    = er_q;
    acc_d   = acc_q;
    i_d     = i_q;
    z_d     = z_q;
    done_d  = 1'b0;
    armed_d = start ? armed_q : 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start && armed_q) begin
          xr_d    = x;
          er_d    = e;
          acc_d   = n_bit'(1);
          armed_d = 1'b0;
`ifdef MOD_EXP_SKIP_LZ_EN
          if (e == '0) begin
            state_d = S_FIN;
          end else begin
            // acc = 1 here, so the squarings above the top set bit are no-ops.
            i_d     = msb_idx(e);
            state_d = S_CHK;
          end
`else
          i_d     = IW'(e_bit - 1);
          state_d = S_SQR;
`endif
        end
      end
      S_SQR: begin
        if (mm_done) begin
          acc_d   = mm_z;
          state_d = S_CHK;
        end
      end
      S_CHK: state_d = er_q[i_q] ? S_MUL : S_NXT;
      S_MUL: begin
        if (mm_done) begin
          acc_d   = mm_z;
          state_d = S_NXT;
        end
      end
      S_NXT: begin
        if (i_q == '0) begin
          state_d = S_FIN;
        end else begin
          i_d     = i_q - 1'b1;
          state_d = S_SQR;
        end
      end
      S_FIN: begin
        z_d     = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      xr_q    <= '0;
      er_q    <= '0;
      acc_q   <= n_bit'(1);
      i_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      er_q    <= er_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      z_q     <= z_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign z    = z_q;
  assign done = done_q;
  // done_q is registered out of FIN, so the state is already IDLE in the done cycle.
  assign busy = (state_q != S_IDLE) || done_q;

endmodule

// File: tb/tb_mod_exp.sv
`timescale 1ns/1ps
module tb_mod_exp;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] x = '0;
  logic [7:0] e = '0;
  logic [6:0] z;
  logic       done;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int gap_viol = 0;
  int mm_ops   = 0;
  int exp_q[$];

  localparam int BUDGET = 400;

  mod_exp dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .e     (e),
    .z     (z),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, and watches the
  // mod_mul handshake for a low start cycle after each mod_mul done.
  task automatic monitor();
    logic prev_mm_done = 1'b0;
    int   exp_z;
    forever begin
      @(negedge clk);
      if (prev_mm_done && dut.mm_start) gap_viol++;
      if (dut.mm_done) mm_ops++;
      prev_mm_done = dut.mm_done;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          exp_z = exp_q.pop_front();
          check("result_z", int'(z), exp_z);
        end
      end
    end
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < BUDGET);
    check(name, int'(done), 1);
  endtask

  // Call at a negedge; returns at the negedge where done is seen.
  task automatic run(input int xv, input int ev, input int zv, output int cyc);
    x     = 7'(xv);
    e     = 8'(ev);
    start = 1'b1;
    exp_q.push_back(zv);
    wait_done($sformatf("done_seen_x%0d_e%0d", xv, ev), cyc);
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int d0;
    fork
      monitor();
    join_none

    // 1. reset values, then a basic run with exactly one done pulse
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_z", int'(z), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    run(17, 3, 15, cyc);
    repeat (4) @(negedge clk);
    check("single_done_pulse", done_cnt - d0, 1);
    check("idle_busy_low", int'(busy), 0);

    // 2. assorted vectors
    run(2, 10, 76, cyc);
    @(negedge clk);
    run(17, 78, 1, cyc);   // Fermat: x^(n-1) = 1
    @(negedge clk);
    run(20, 1, 20, cyc);
    @(negedge clk);

    // 3. boundaries
    run(45, 0, 1, cyc);
`ifdef MOD_EXP_SKIP_LZ_EN
    check("skip_e0_latency", cyc, 2);
`endif
    @(negedge clk);
    run(0, 5, 0, cyc);
    @(negedge clk);

    // 4. start pulse while busy is ignored
    d0 = done_cnt;
    x = 7'd17; e = 8'd3; start = 1'b1;
    exp_q.push_back(15);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_during_op", int'(busy), 1);
    x = 7'd3; e = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("done_seen_busy_ignore", cyc);
    repeat (30) @(negedge clk);
    check("busy_ignore_one_done", done_cnt - d0, 1);
    check("busy_ignore_z_held", int'(z), 15);

    // 5. reset in the middle of a MUL step
    d0 = done_cnt;
    x = 7'd17; e = 8'd3; start = 1'b1;
    exp_q.push_back(15);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (dut.state_q != 3'd3 && cyc < BUDGET);
    check("reached_mul", int'(dut.state_q), 3);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_z", int'(z), 0);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_stays_idle", int'(busy), 0);
    run(17, 3, 15, cyc);
    @(negedge clk);

    // 6. start held through done: no retrigger until it drops for one cycle
    d0 = done_cnt;
    x = 7'd17; e = 8'd3; start = 1'b1;
    exp_q.push_back(15);
    wait_done("done_seen_held_start", cyc);
    repeat (40) @(negedge clk);
    check("held_start_no_retrigger", done_cnt - d0, 1);
    check("held_start_busy_low", int'(busy), 0);
    check("held_start_z_held", int'(z), 15);
    start = 1'b0;
    @(negedge clk);
    run(20, 2, 5, cyc);
    repeat (4) @(negedge clk);
    check("back_to_back_dones", done_cnt - d0, 2);

    check("mm_ops_observed", int'(mm_ops > 0), 1);
    check("mm_start_gap_violations", gap_viol, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
